// File: rtl/wb_burst_arbiter_if.sv
// ----------------------------------------------------------------------------
// wb_burst_arbiter_if : shared bus bundle between NM Wishbone masters and one slave
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface wb_burst_arbiter_if #(
   parameter int aw = 32,
   parameter int dw = 32,
   parameter int NM = 4
);
   logic [NM*aw-1:0] m_adr_i;
   logic [NM*dw-1:0] m_dat_i;
   logic [NM*4-1:0]  m_sel_i;
   logic [NM-1:0]    m_we_i;
   logic [NM-1:0]    m_cyc_i;
   logic [NM-1:0]    m_stb_i;
   logic [NM*3-1:0]  m_cti_i;
   logic [NM*2-1:0]  m_bte_i;
   logic [NM*dw-1:0] m_dat_o;
   logic [NM-1:0]    m_ack_o;
   logic [NM-1:0]    m_err_o;
   logic [NM-1:0]    m_rty_o;

   logic [aw-1:0]    s_adr_o;
   logic [dw-1:0]    s_dat_o;
   logic [3:0]       s_sel_o;
   logic             s_we_o;
   logic             s_cyc_o;
   logic             s_stb_o;
   logic [2:0]       s_cti_o;
   logic [1:0]       s_bte_o;
   logic [dw-1:0]    s_dat_i;
   logic             s_ack_i;
   logic             s_err_i;
   logic             s_rty_i;

   // The arbiter itself: receives master requests and slave responses.
   modport slave (
      input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
      input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
      output m_dat_o, m_ack_o, m_err_o, m_rty_o,
      output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o
   );

   // The surrounding system: masters and the shared slave.
   modport master (
      output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, m_cti_i, m_bte_i,
      output s_dat_i, s_ack_i, s_err_i, s_rty_i,
      input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
      input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o
   );
endinterface

`default_nettype wire

// File: rtl/wb_burst_arbiter.sv
// ----------------------------------------------------------------------------
// wb_burst_arbiter : round-robin Wishbone arbiter, grant held per cycle, watchdog
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wb_burst_arbiter #(
   parameter int aw      = 32,
   parameter int dw      = 32,
   parameter int NM      = 4,
   parameter int TIMEOUT = 256
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   wb_burst_arbiter_if.slave    bus,
   output logic [NM-1:0]        grant_o
);
   localparam int IW = (NM > 1) ? $clog2(NM) : 1;
   localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [0:0] {IDLE = 1'b0, OWNED = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [NM-1:0]   grant_q, grant_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [WW-1:0]   wd_q, wd_d;

   logic            owned, own_cyc, own_stb, wd_fire, s_term, found;
   logic [IW-1:0]   pick;
   int              j;

   assign owned   = (state_q == OWNED);
   assign own_cyc = bus.m_cyc_i[idx_q];
   assign own_stb = bus.m_stb_i[idx_q];
   assign s_term  = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
   assign wd_fire = (TIMEOUT != 0) && owned && (wd_q == WW'(TIMEOUT));
   assign grant_o = grant_q;

   // Rotating priority search starting at ptr.
   always_comb begin
      found = 1'b0;
      pick  = ptr_q;
      j     = 0;
      for (int i = 0; i < NM; i++) begin
         j = int'(ptr_q) + i;
         if (j >= NM) j = j - NM;
         if (!found && bus.m_cyc_i[j]) begin
            found = 1'b1;
            pick  = IW'(j);
         end
      end
   end

   always_comb begin
      bus.s_adr_o = '0;
      bus.s_dat_o = '0;
      bus.s_sel_o = '0;
      bus.s_we_o  = 1'b0;
      bus.s_cyc_o = 1'b0;
      bus.s_stb_o = 1'b0;
      bus.s_cti_o = '0;
      bus.s_bte_o = '0;
      if (owned) begin
         bus.s_adr_o = bus.m_adr_i[int'(idx_q)*aw +: aw];
         bus.s_dat_o = bus.m_dat_i[int'(idx_q)*dw +: dw];
         bus.s_sel_o = bus.m_sel_i[int'(idx_q)*4 +: 4];
         bus.s_we_o  = bus.m_we_i[idx_q];
         bus.s_cyc_o = own_cyc;
         bus.s_stb_o = own_stb & ~wd_fire;
         bus.s_cti_o = bus.m_cti_i[int'(idx_q)*3 +: 3];
         bus.s_bte_o = bus.m_bte_i[int'(idx_q)*2 +: 2];
      end
   end

   // grant_q is all-zero outside OWNED, so it doubles as the termination mask.
   assign bus.m_dat_o = {NM{bus.s_dat_i}};
   assign bus.m_ack_o = grant_q & {NM{bus.s_ack_i}};
   assign bus.m_err_o = grant_q & {NM{bus.s_err_i | wd_fire}};
   assign bus.m_rty_o = grant_q & {NM{bus.s_rty_i}};

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      wd_d    = wd_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = OWNED;
               grant_d = NM'(1) << pick;
               idx_d   = pick;
            end
         end
         OWNED: begin
            if (!own_cyc) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = (int'(idx_q) == NM - 1) ? '0 : idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if ((state_d != state_q) || s_term || wd_fire || (TIMEOUT == 0))
         wd_d = '0;
      else if (owned && bus.s_stb_o)
         wd_d = wd_q + 1'b1;
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         wd_q    <= wd_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_wb_burst_arbiter.sv
// ----------------------------------------------------------------------------
// tb_wb_burst_arbiter : directed self-checking bench for wb_burst_arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_wb_burst_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int N  = 4;
   localparam int TO = 16;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  grant;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   wb_burst_arbiter_if #(.aw(AW), .dw(DW), .NM(N)) bus ();

   wb_burst_arbiter #(.aw(AW), .dw(DW), .NM(N), .TIMEOUT(TO)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst_n),
      .bus      (bus),
      .grant_o  (grant)
   );

   function automatic logic [AW-1:0] adr_of(input int k);
      return 32'hA000_0000 + 32'(k * 16);
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_m(input int k, input logic cyc, input logic stb, input logic [2:0] cti);
      bus.m_cyc_i[k]       = cyc;
      bus.m_stb_i[k]       = stb;
      bus.m_cti_i[k*3 +: 3] = cti;
   endtask

   task automatic test_reset;
      drive_m(1, 1'b1, 1'b1, 3'b000);
      tick; tick;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant got %b exp 0000", grant); end
      checks++; if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0) begin errors++; $display("FAIL rst_ctl got cyc=%b stb=%b exp 0/0", bus.s_cyc_o, bus.s_stb_o); end
      checks++; if (bus.s_adr_o !== 32'h0) begin errors++; $display("FAIL rst_adr got %h exp 0", bus.s_adr_o); end
      drive_m(1, 1'b0, 1'b0, 3'b000);
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_contention;
      drive_m(0, 1'b1, 1'b1, 3'b000);
      drive_m(3, 1'b1, 1'b1, 3'b000);
      #1;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL cont_latency got %b exp 0000", grant); end
      tick;
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL cont_first got %b exp 0001", grant); end
      checks++; if (bus.s_adr_o !== adr_of(0)) begin errors++; $display("FAIL cont_adr0 got %h exp %h", bus.s_adr_o, adr_of(0)); end
      bus.s_ack_i = 1'b1; #1;
      checks++; if (bus.m_ack_o !== 4'b0001) begin errors++; $display("FAIL cont_ack got %b exp 0001", bus.m_ack_o); end
      tick;
      bus.s_ack_i = 1'b0;
      drive_m(0, 1'b0, 1'b0, 3'b000);
      tick;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL cont_dead got %b exp 0000", grant); end
      checks++; if (bus.s_cyc_o !== 1'b0 || bus.s_adr_o !== 32'h0) begin errors++; $display("FAIL cont_idle_out got cyc=%b adr=%h exp 0/0", bus.s_cyc_o, bus.s_adr_o); end
      tick;
      checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL cont_second got %b exp 1000", grant); end
      checks++; if (bus.s_adr_o !== adr_of(3)) begin errors++; $display("FAIL cont_adr3 got %h exp %h", bus.s_adr_o, adr_of(3)); end
      drive_m(3, 1'b0, 1'b0, 3'b000);
      tick;
   endtask

   task automatic test_single;
      drive_m(2, 1'b1, 1'b1, 3'b000);
      #1;
      checks++; if (grant !== 4'b0000 || bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL single_pre got grant=%b cyc=%b exp 0000/0", grant, bus.s_cyc_o); end
      tick;
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant got %b exp 0100", grant); end
      checks++; if (bus.s_adr_o !== adr_of(2)) begin errors++; $display("FAIL single_adr got %h exp %h", bus.s_adr_o, adr_of(2)); end
      checks++; if (bus.s_sel_o !== 4'b0100 || bus.s_we_o !== 1'b0 || bus.s_cyc_o !== 1'b1 || bus.s_stb_o !== 1'b1) begin
         errors++; $display("FAIL single_ctl got sel=%b we=%b cyc=%b stb=%b exp 0100/0/1/1", bus.s_sel_o, bus.s_we_o, bus.s_cyc_o, bus.s_stb_o); end
      checks++; if (bus.s_dat_o !== 32'hD000_0002) begin errors++; $display("FAIL single_wdat got %h exp D0000002", bus.s_dat_o); end
      bus.s_ack_i = 1'b1;
      bus.s_dat_i = 32'hCAFE_F00D;
      #1;
      checks++; if (bus.m_ack_o !== 4'b0100) begin errors++; $display("FAIL single_ack got %b exp 0100", bus.m_ack_o); end
      checks++; if (bus.m_dat_o !== {4{32'hCAFE_F00D}}) begin errors++; $display("FAIL single_rdat got %h", bus.m_dat_o); end
      tick;
      bus.s_ack_i = 1'b0;
      drive_m(2, 1'b0, 1'b0, 3'b000);
      #1;
      checks++; if (grant !== 4'b0100 || bus.s_cyc_o !== 1'b0) begin errors++; $display("FAIL single_drop got grant=%b cyc=%b exp 0100/0", grant, bus.s_cyc_o); end
      tick;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_release got %b exp 0000", grant); end
   endtask

   task automatic test_burst;
      int acks = 0;
      drive_m(1, 1'b1, 1'b1, 3'b010);
      tick;
      checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL burst_grant got %b exp 0010", grant); end
      drive_m(0, 1'b1, 1'b1, 3'b000);
      for (int b = 0; b < 8; b++) begin
         if (b == 4) begin
            drive_m(1, 1'b1, 1'b0, 3'b010);
            bus.s_ack_i = 1'b0;
            #1;
            checks++; if (bus.s_stb_o !== 1'b0 || grant !== 4'b0010) begin errors++; $display("FAIL burst_wait got stb=%b grant=%b exp 0/0010", bus.s_stb_o, grant); end
            tick;
         end
         drive_m(1, 1'b1, 1'b1, (b == 7) ? 3'b111 : 3'b010);
         bus.s_ack_i = 1'b1;
         #1;
         checks++; if (bus.m_ack_o !== 4'b0010 || grant !== 4'b0010) begin errors++; $display("FAIL burst_beat%0d got ack=%b grant=%b exp 0010/0010", b, bus.m_ack_o, grant); end
         if (bus.m_ack_o[1] === 1'b1) acks++;
         if (b == 7) begin
            checks++; if (bus.s_cti_o !== 3'b111) begin errors++; $display("FAIL burst_cti got %b exp 111", bus.s_cti_o); end
         end
         tick;
      end
      bus.s_ack_i = 1'b0;
      drive_m(1, 1'b0, 1'b0, 3'b000);
      #1;
      checks++; if (acks != 8) begin errors++; $display("FAIL burst_acks got %0d exp 8", acks); end
      tick;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL burst_dead got %b exp 0000", grant); end
      tick;
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL burst_next got %b exp 0001", grant); end
      drive_m(0, 1'b0, 1'b0, 3'b000);
      tick;
   endtask

   task automatic test_watchdog;
      drive_m(0, 1'b1, 1'b1, 3'b000);
      tick;
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL wd_grant got %b exp 0001", grant); end
      for (int k = 0; k < TO; k++) begin
         checks++; if (bus.m_err_o !== 4'b0000 || bus.s_stb_o !== 1'b1) begin errors++; $display("FAIL wd_early%0d got err=%b stb=%b exp 0000/1", k, bus.m_err_o, bus.s_stb_o); end
         tick;
      end
      checks++; if (bus.m_err_o !== 4'b0001 || bus.s_stb_o !== 1'b0) begin errors++; $display("FAIL wd_fire got err=%b stb=%b exp 0001/0", bus.m_err_o, bus.s_stb_o); end
      tick;
      checks++; if (bus.m_err_o !== 4'b0000 || bus.s_stb_o !== 1'b1 || grant !== 4'b0001) begin
         errors++; $display("FAIL wd_after got err=%b stb=%b grant=%b exp 0000/1/0001", bus.m_err_o, bus.s_stb_o, grant); end
      drive_m(0, 1'b0, 1'b0, 3'b000);
      tick;
   endtask

   task automatic test_reset_mid;
      drive_m(2, 1'b1, 1'b1, 3'b010);
      tick;
      checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL rmid_grant got %b exp 0100", grant); end
      bus.s_ack_i = 1'b1;
      tick; tick;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.s_cyc_o !== 1'b0 || bus.s_stb_o !== 1'b0 || grant !== 4'b0000) begin
         errors++; $display("FAIL rmid_abort got cyc=%b stb=%b grant=%b exp 0/0/0000", bus.s_cyc_o, bus.s_stb_o, grant); end
      checks++; if (bus.m_ack_o !== 4'b0000) begin errors++; $display("FAIL rmid_noack got %b exp 0000", bus.m_ack_o); end
      bus.s_ack_i = 1'b0;
      drive_m(2, 1'b0, 1'b0, 3'b000);
      drive_m(0, 1'b1, 1'b1, 3'b000);
      drive_m(1, 1'b1, 1'b1, 3'b000);
      tick;
      rst_n = 1'b1;
      tick;
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rmid_restart got %b exp 0001", grant); end
      checks++; if (bus.s_adr_o !== adr_of(0)) begin errors++; $display("FAIL rmid_adr got %h exp %h", bus.s_adr_o, adr_of(0)); end
      drive_m(0, 1'b0, 1'b0, 3'b000);
      drive_m(1, 1'b0, 1'b0, 3'b000);
      tick;
   endtask

   initial begin
      for (int k = 0; k < N; k++) begin
         bus.m_adr_i[k*AW +: AW] = adr_of(k);
         bus.m_dat_i[k*DW +: DW] = 32'hD000_0000 + 32'(k);
         bus.m_sel_i[k*4 +: 4]   = 4'(1 << k);
         bus.m_we_i[k]           = k[0];
         bus.m_bte_i[k*2 +: 2]   = 2'(k);
      end
      bus.m_cyc_i = '0;
      bus.m_stb_i = '0;
      bus.m_cti_i = '0;
      bus.s_dat_i = '0;
      bus.s_ack_i = 1'b0;
      bus.s_err_i = 1'b0;
      bus.s_rty_i = 1'b0;
      #2;
      test_reset();
      test_contention();
      test_single();
      test_burst();
      test_watchdog();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout got no completion exp finish");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
